// File: rtl/ula.sv
// ula - 16-bit (parameterisable) arithmetic logic unit with registered result.
//
// Operations (op): 00 ADD, 01 SUB, 10 AND, 11 OR. Operands are captured on
// the rising clk edge while in_valid is high; C, flags and out_valid update
// together one cycle later. With in_valid low, C and flags hold and
// out_valid drops.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset (clears C, flags, out_valid)
//   in_valid   A/B/op valid this cycle
//   A, B       WIDTH-bit operands
//   op         2-bit opcode
//   C          WIDTH-bit registered result
//   out_valid  one-cycle strobe marking a new result in C
//   flags      {N, Z, Cy, V}, registered alongside C
//
// Optional feature: define ULA_FLAGS_EN to build the status flag logic.
// Without it, flags is tied to 4'b0000 and no flag registers exist.
module ula #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] C,
   output logic             out_valid,
   output logic [3:0]       flags
);

   localparam int unsigned MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   logic [WIDTH-1:0] result;

   always_comb begin
      result = '0;
      case (op_e'(op))
         OP_ADD: result = A + B;
         OP_SUB: result = A - B;
         OP_AND: result = A & B;
         OP_OR:  result = A | B;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         C         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            C <= result;
         end
      end
   end

`ifdef ULA_FLAGS_EN
   logic cy;
   logic v;

   // Carry out of the MSB is recovered from the operand and result sign
   // bits, so no extra adder bit is needed: a carry leaves the top stage
   // when both inputs are 1, or when either is 1 and the sum bit came out 0.
   always_comb begin
      cy = 1'b0;
      v  = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            cy = (A[MSB] & B[MSB]) | ((A[MSB] | B[MSB]) & ~result[MSB]);
            v  = (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]);
         end
         OP_SUB: begin
            cy = (A < B);
            v  = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]);
         end
         default: begin
            cy = 1'b0;
            v  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
      end else if (in_valid) begin
         flags <= {result[MSB], (result == '0), cy, v};
      end
   end
`else
   assign flags = '0;
`endif

endmodule

// File: tb/tb_ula.sv
module tb_ula;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] A;
   logic [15:0] B;
   logic [1:0]  op;
   logic [15:0] C;
   logic        out_valid;
   logic [3:0]  flags;

   ula #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .op        (op),
      .C         (C),
      .out_valid (out_valid),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] c;
      logic [3:0]  f;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] last_c   = '0;
   logic [3:0]  last_f   = '0;

   // Reference model: carry/borrow from wide unsigned math, overflow from
   // signed-range checks on 32-bit integers.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] o);
      exp_t        e;
      int unsigned ua;
      int unsigned ub;
      int unsigned ur;
      int          sa;
      int          sbv;
      int          r;
      logic        cy;
      logic        v;
      logic [15:0] c;
      ua  = 32'(a);
      ub  = 32'(b);
      sa  = 32'($signed(a));
      sbv = 32'($signed(b));
      cy  = 1'b0;
      v   = 1'b0;
      c   = '0;
      case (o)
         2'b00: begin
            ur = ua + ub;
            c  = ur[15:0];
            cy = (ur > 32'd65535);
            r  = sa + sbv;
            v  = (r > 32767) || (r < -32768);
         end
         2'b01: begin
            ur = ua - ub;
            c  = ur[15:0];
            cy = (ua < ub);
            r  = sa - sbv;
            v  = (r > 32767) || (r < -32768);
         end
         2'b10: c = a & b;
         default: c = a | b;
      endcase
      e.c = c;
`ifdef ULA_FLAGS_EN
      e.f = {c[15], (c == 16'h0000), cy, v};
`else
      e.f = 4'b0000;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of stimulus, let the DUT capture it, then compare the
   // produced output against the scoreboard.
   task automatic step(input string tag, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] o);
      exp_t e;
      in_valid = v;
      A        = a;
      B        = b;
      op       = o;
      if (v) sb.push_back(model(a, b, o));
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      if (out_valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         last_c = e.c;
         last_f = e.f;
      end
      check({tag, ".C"}, 32'(C), 32'(last_c));
      check({tag, ".flags"}, 32'(flags), 32'(last_f));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      op       = '0;
      #1;
      check("reset.C", 32'(C), 32'h0);
      check("reset.out_valid", 32'(out_valid), 32'h0);
      check("reset.flags", 32'(flags), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_hold.out_valid", 32'(out_valid), 32'h0);
      rst = 1'b0;

      step("sub_1_9",  1'b1, 16'h0001, 16'h0009, 2'b01);
      step("and_9_8",  1'b1, 16'h0009, 16'h0008, 2'b10);
      step("or_2_9",   1'b1, 16'h0002, 16'h0009, 2'b11);
      step("add_2_9",  1'b1, 16'h0002, 16'h0009, 2'b00);
      step("add_ovf",  1'b1, 16'h7FFF, 16'h0001, 2'b00);
      step("add_wrap", 1'b1, 16'hFFFF, 16'h0001, 2'b00);
      step("sub_0_1",  1'b1, 16'h0000, 16'h0001, 2'b01);
      step("sub_ovf",  1'b1, 16'h8000, 16'h0001, 2'b01);
      step("sub_eq",   1'b1, 16'h1234, 16'h1234, 2'b01);
      step("and_zero", 1'b1, 16'hF0F0, 16'h0F0F, 2'b10);
      step("idle1",    1'b0, 16'hAAAA, 16'h5555, 2'b00);
      step("idle2",    1'b0, 16'h1111, 16'h2222, 2'b11);

      for (int i = 0; i < 12; i++) begin
         step("rand", 1'b1, 16'($urandom), 16'($urandom),
              2'($urandom_range(3, 0)));
      end

      // Asynchronous reset mid-cycle with an operation in flight.
      step("pre_rst", 1'b1, 16'h00F0, 16'h000F, 2'b11);
      in_valid = 1'b1;
      A        = 16'h0005;
      B        = 16'h0003;
      op       = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.C", 32'(C), 32'h0);
      check("async_rst.out_valid", 32'(out_valid), 32'h0);
      check("async_rst.flags", 32'(flags), 32'h0);
      @(posedge clk);
      #1;
      check("rst_held.C", 32'(C), 32'h0);
      check("rst_held.out_valid", 32'(out_valid), 32'h0);
      rst    = 1'b0;
      last_c = '0;
      last_f = '0;
      step("post_rst_idle", 1'b0, 16'h0005, 16'h0003, 2'b00);
      step("post_rst_add",  1'b1, 16'h0005, 16'h0003, 2'b00);

      check("scoreboard_empty", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ula.md
Name:
ula

Overview:
- 16-bit arithmetic logic unit with a registered result: two operands, 2-bit opcode, four operations (ADD, SUB, AND, OR).
- Sits behind the board-level top; operands and opcode come from switches or an upstream datapath, and the result drives LEDs or a downstream register.
- One-cycle latency with a simple valid strobe, plus optional status flags.

Parameters:
- WIDTH, 16, operand and result width in bits (all behaviour is specified for 16; must work for any WIDTH >= 2)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  A/B/op are valid this cycle; operation is captured at the next rising clk
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- C  output  WIDTH  registered result
- out_valid  output  1  high for exactly one cycle when C holds a new result
- flags  output  4  {N, Z, Cy, V}, registered together with C

Behaviour:
- Reset (rst=1, asynchronous): C=0, out_valid=0, flags=0, held for as long as rst is high. First capture is at the first rising clk after rst falls.
- Rising clk with in_valid=1: C, flags and out_valid=1 are all updated together. Latency is exactly 1 cycle.
- Rising clk with in_valid=0: out_valid=0; C and flags hold their previous values.
- Back-to-back in_valid is supported: one result per cycle, no stall, no backpressure.
- ADD: C = (A+B) mod 2^WIDTH. Cy = carry out of the MSB (bit WIDTH of the WIDTH+1-bit sum).
- SUB: C = (A-B) mod 2^WIDTH, two's complement. Cy = borrow, i.e. 1 when A < B unsigned.
- AND: C = A & B, bitwise.
- OR: C = A | B, bitwise.
- AND/OR: Cy=0 and V=0.
- V (ADD): 1 when A and B have the same sign and the result sign differs.
- V (SUB): 1 when A and B have different signs and the result sign differs from A.
- N = C[WIDTH-1]. Z = 1 when C == 0.
- Wrap-around: 0xFFFF+1 gives C=0, Cy=1, Z=1. 0-1 gives C=0xFFFF, Cy=1, N=1.
- Reset asserted while in_valid is high: reset wins and the in-flight operation is discarded (out_valid=0).
- All opcode values are defined; there is no illegal opcode.

Optional Feature:
- Macro: ULA_FLAGS_EN.
- Defined: the flags port is driven as specified above.
- Not defined: the flags port is tied to 4'b0000, the flag logic and flag registers are not synthesized, and C/out_valid behaviour is unchanged.

Test Plan:
- Reset, then A=0x0001, B=0x0009, op=01, in_valid=1 -> next cycle: C=0xFFF8, out_valid=1, N=1, Z=0, Cy=1, V=0.
- A=0x0009, B=0x0008, op=10 -> C=0x0008, Cy=0, V=0, Z=0. Then A=0x0002, B=0x0009, op=11 -> C=0x000B.
- A=0x0002, B=0x0009, op=00 -> C=0x000B, flags=0000. A=0x7FFF, B=0x0001, op=00 -> C=0x8000, N=1, V=1, Cy=0. A=0xFFFF, B=0x0001, op=00 -> C=0x0000, Z=1, Cy=1.
- Four back-to-back in_valid cycles (the ops above) -> four consecutive out_valid pulses with matching results. Then drop in_valid -> out_valid=0 and C holds.
- Assert rst asynchronously mid-clock while in_valid=1 -> C=0, flags=0, out_valid=0 immediately, and no result emitted for the in-flight operation.
- Build without ULA_FLAGS_EN, rerun the cases above -> identical C values, flags always 0000.
